// File: rtl/decoder_seq_n.sv
// decoder_seq_n: registered, parametrised index-to-one-hot decoder with a
// valid/ready input handshake and four run-time modes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode       00=LEVEL, 01=PULSE, 10=SCAN, 11=OFF
//   data_in    index to decode
//   in_valid   data_in is valid
//   in_ready   block can accept data_in this cycle (combinational)
//   data_out   registered decoded lines (inverted when ACTIVE_LOW=1)
//   out_valid  registered; high when exactly one line is asserted
//   idx_out    registered index of the asserted line; 0 when out_valid=0
module decoder_seq_n #(
  parameter int unsigned IN_W       = 3,
  parameter int unsigned PULSE_LEN  = 4,
  parameter bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W     = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid,
  output logic [IN_W-1:0]  idx_out
);

  localparam logic [1:0] ModeLevel = 2'b00;
  localparam logic [1:0] ModePulse = 2'b01;
  localparam logic [1:0] ModeScan  = 2'b10;
  localparam logic [1:0] ModeOff   = 2'b11;

  localparam logic [7:0]       CntLoad   = 8'(PULSE_LEN - 1);
  localparam logic [OUT_W-1:0] OneBit    = OUT_W'(1);
  localparam logic [OUT_W-1:0] OutIdle   = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {StIdle, StHold, StPulse, StScan} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       mode_q;
  logic [OUT_W-1:0] data_out_d;
  logic             out_valid_d;
  logic [IN_W-1:0]  idx_out_d;
  logic             mode_chg;
  logic             accept;
  logic [OUT_W-1:0] onehot_d;

  // A mode change overrides everything else in the cycle it is seen.
  assign mode_chg = (mode != mode_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!mode_chg) begin
      unique case (state_q)
        StIdle:  in_ready = (mode == ModeLevel) || (mode == ModePulse);
        StHold:  in_ready = (mode == ModeLevel);
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (mode_chg) begin
      cnt_d = 8'd0;
      if (mode == ModeScan) begin
        state_d = StScan;
        idx_d   = '0;
      end else begin
        state_d = StIdle;
      end
    end else if (mode == ModeOff) begin
      state_d = StIdle;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mode == ModeScan) begin
            state_d = StScan;
            idx_d   = '0;
          end else if (accept) begin
            idx_d = data_in;
            if (mode == ModeLevel) begin
              state_d = StHold;
            end else begin
              state_d = StPulse;
              cnt_d   = CntLoad;
            end
          end
        end
        StHold: begin
          if (mode != ModeLevel) begin
            state_d = StIdle;
          end else if (accept) begin
            idx_d = data_in;
          end
        end
        StPulse: begin
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StScan: begin
          if (mode != ModeScan) begin
            state_d = StIdle;
          end else begin
            // Natural IN_W-bit overflow wraps OUT_W-1 back to 0.
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered from the next state so the line follows an accept by one edge.
    out_valid_d = (state_d != StIdle);
    idx_out_d   = out_valid_d ? idx_d : '0;
    onehot_d    = out_valid_d ? (OneBit << idx_d) : '0;
    data_out_d  = ACTIVE_LOW ? ~onehot_d : onehot_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= 8'd0;
      mode_q    <= ModeLevel;
      data_out  <= OutIdle;
      out_valid <= 1'b0;
      idx_out   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode;
      data_out  <= data_out_d;
      out_valid <= out_valid_d;
      idx_out   <= idx_out_d;
    end
  end

endmodule

// File: tb/tb_decoder_seq_n.sv
module tb_decoder_seq_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [2:0] data_in;
  logic       in_valid;
  logic       in_ready, in_ready_al;
  logic [7:0] data_out, data_out_al;
  logic       out_valid, out_valid_al;
  logic [2:0] idx_out, idx_out_al;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_seq_n #(.IN_W(3), .PULSE_LEN(3), .ACTIVE_LOW(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .idx_out  (idx_out)
  );

  decoder_seq_n #(.IN_W(3), .PULSE_LEN(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready_al),
    .data_out (data_out_al),
    .out_valid(out_valid_al),
    .idx_out  (idx_out_al)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 2'b00; data_in = 3'bxxx; in_valid = 1'b0;
    #12;
    n_cmp++; if (data_out !== 8'h00) begin
      $display("FAIL reset_data_out got %h want 00", data_out); n_fail++; end
    n_cmp++; if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got %b want 0", out_valid); n_fail++; end
    n_cmp++; if (idx_out !== 3'd0) begin
      $display("FAIL reset_idx_out got %0d want 0", idx_out); n_fail++; end
    n_cmp++; if (data_out_al !== 8'hFF) begin
      $display("FAIL reset_data_out_al got %h want ff", data_out_al); n_fail++; end
    rst = 1'b0;
    tick();
    // X on data_in with in_valid low must not leak out.
    n_cmp++; if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      $display("FAIL idle_x_data_in got %h/%b want 00/0", data_out, out_valid); n_fail++; end
    n_cmp++; if (in_ready !== 1'b1) begin
      $display("FAIL idle_level_ready got %b want 1", in_ready); n_fail++; end
  endtask

  task automatic test_level;
    data_in = 3'd5; in_valid = 1'b1;
    tick();
    n_cmp++; if (data_out !== 8'b0010_0000 || out_valid !== 1'b1 || idx_out !== 3'd5) begin
      $display("FAIL level_accept5 got %h/%b/%0d want 20/1/5", data_out, out_valid, idx_out);
      n_fail++; end
    n_cmp++; if (in_ready !== 1'b1) begin
      $display("FAIL hold_ready got %b want 1", in_ready); n_fail++; end
    data_in = 3'd2;
    tick();
    n_cmp++; if (data_out !== 8'b0000_0100 || idx_out !== 3'd2) begin
      $display("FAIL level_replace2 got %h/%0d want 04/2", data_out, idx_out); n_fail++; end
    data_in = 3'd2;
    tick();
    n_cmp++; if (data_out !== 8'b0000_0100 || out_valid !== 1'b1) begin
      $display("FAIL level_same_idx got %h/%b want 04/1", data_out, out_valid); n_fail++; end
    in_valid = 1'b0; data_in = 3'bxxx;
    tick();
    n_cmp++; if (data_out !== 8'b0000_0100) begin
      $display("FAIL level_hold got %h want 04", data_out); n_fail++; end
  endtask

  task automatic test_pulse;
    mode = 2'b01;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin
      $display("FAIL mode_chg_ready got %b want 0", in_ready); n_fail++; end
    tick();
    n_cmp++; if (data_out !== 8'h00 || out_valid !== 1'b0 || idx_out !== 3'd0) begin
      $display("FAIL hold_abort got %h/%b/%0d want 00/0/0", data_out, out_valid, idx_out);
      n_fail++; end
    n_cmp++; if (in_ready !== 1'b1) begin
      $display("FAIL pulse_idle_ready got %b want 1", in_ready); n_fail++; end
    data_in = 3'd7; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'b0;
      #1;
      n_cmp++; if (data_out !== 8'h80 || out_valid !== 1'b1 || idx_out !== 3'd7) begin
        $display("FAIL pulse_on[%0d] got %h/%b/%0d want 80/1/7", i, data_out, out_valid,
                 idx_out);
        n_fail++; end
      n_cmp++; if (in_ready !== 1'b0) begin
        $display("FAIL pulse_ready[%0d] got %b want 0", i, in_ready); n_fail++; end
    end
    tick();
    n_cmp++; if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      $display("FAIL pulse_end got %h/%b want 00/0", data_out, out_valid); n_fail++; end
    n_cmp++; if (in_ready !== 1'b1) begin
      $display("FAIL pulse_end_ready got %b want 1", in_ready); n_fail++; end
  endtask

  task automatic test_scan;
    logic [7:0] exp_out;
    logic [2:0] exp_idx;
    mode = 2'b10;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      data_in  = 3'(i * 3);
      tick();
      exp_idx = 3'(i % 8);
      exp_out = 8'd1 << exp_idx;
      n_cmp++; if (idx_out !== exp_idx || data_out !== exp_out || out_valid !== 1'b1) begin
        $display("FAIL scan[%0d] got %0d/%h/%b want %0d/%h/1", i, idx_out, data_out, out_valid,
                 exp_idx, exp_out);
        n_fail++; end
      n_cmp++; if (in_ready !== 1'b0) begin
        $display("FAIL scan_ready[%0d] got %b want 0", i, in_ready); n_fail++; end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mode_change;
    mode = 2'b01;
    tick();
    n_cmp++; if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      $display("FAIL scan_abort got %h/%b want 00/0", data_out, out_valid); n_fail++; end
    data_in = 3'd3; in_valid = 1'b1;
    tick();
    n_cmp++; if (data_out !== 8'h08) begin
      $display("FAIL pulse3_on got %h want 08", data_out); n_fail++; end
    in_valid = 1'b0; mode = 2'b00;
    tick();
    n_cmp++; if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      $display("FAIL pulse_abort got %h/%b want 00/0", data_out, out_valid); n_fail++; end
    n_cmp++; if (in_ready !== 1'b1) begin
      $display("FAIL abort_idle_ready got %b want 1", in_ready); n_fail++; end
    data_in = 3'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (data_out !== 8'h10 || out_valid !== 1'b1 || idx_out !== 3'd4) begin
      $display("FAIL level4_held got %h/%b/%0d want 10/1/4", data_out, out_valid, idx_out);
      n_fail++; end
  endtask

  task automatic test_async_reset;
    // Mid-hold (index 4 held from the previous test).
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      $display("FAIL async_rst_hold got %h/%b want 00/0", data_out, out_valid); n_fail++; end
    #1 rst = 1'b0;
    mode = 2'b10;
    tick(); tick(); tick();
    n_cmp++; if (idx_out !== 3'd2) begin
      $display("FAIL prescan got %0d want 2", idx_out); n_fail++; end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (data_out !== 8'h00 || out_valid !== 1'b0 || idx_out !== 3'd0) begin
      $display("FAIL async_rst_scan got %h/%b/%0d want 00/0/0", data_out, out_valid, idx_out);
      n_fail++; end
    #1 rst = 1'b0;
    tick();
    n_cmp++; if (idx_out !== 3'd0 || data_out !== 8'h01 || out_valid !== 1'b1) begin
      $display("FAIL scan_restart got %0d/%h want 0/01", idx_out, data_out); n_fail++; end
    tick();
    n_cmp++; if (idx_out !== 3'd1 || data_out !== 8'h02) begin
      $display("FAIL scan_restart_next got %0d/%h want 1/02", idx_out, data_out); n_fail++; end
  endtask

  task automatic test_active_low;
    #2 rst = 1'b1; mode = 2'b00;
    #2 rst = 1'b0;
    tick();
    data_in = 3'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (data_out_al !== 8'hFE || out_valid_al !== 1'b1 || idx_out_al !== 3'd0) begin
      $display("FAIL al_level0 got %h/%b/%0d want fe/1/0", data_out_al, out_valid_al,
               idx_out_al);
      n_fail++; end
    n_cmp++; if (data_out !== 8'h01) begin
      $display("FAIL ah_level0 got %h want 01", data_out); n_fail++; end
    mode = 2'b11;
    tick();
    n_cmp++; if (data_out_al !== 8'hFF || out_valid_al !== 1'b0) begin
      $display("FAIL al_off got %h/%b want ff/0", data_out_al, out_valid_al); n_fail++; end
    n_cmp++; if (in_ready_al !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL off_ready got %b/%b want 0/0", in_ready_al, in_ready); n_fail++; end
    in_valid = 1'b1; data_in = 3'd6;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (data_out_al !== 8'hFF || data_out !== 8'h00) begin
      $display("FAIL off_ignores got %h/%h want ff/00", data_out_al, data_out); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_scan();
    test_mode_change();
    test_async_reset();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
